display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit seven-segment display. Cycles through digits 0–3 with a programmable dwell and an anti-ghosting blank gap. Drives the 2-bit digit select and enable of the downstream 1-to-4 digit-enable demux, and presents the matching BCD digit and decimal point to the segment decoder. Digit data is double-buffered so a new value never tears mid-frame.

---
 rtl/display_scan_ctrl_pkg.sv | 10 +
 rtl/display_scan_ctrl_dwell_timer.sv | 19 +
 rtl/display_scan_ctrl.sv | 100 ++++++++++
 tb/tb_display_scan_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// display_scan_ctrl_pkg: shared digit constants, FSM encoding and display data type
package display_scan_ctrl_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int BCD_W = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;
    typedef struct packed {
        logic [NUM_DIGITS*BCD_W-1:0] digits;
        logic [NUM_DIGITS-1:0]       dp;
    } disp_t;
endpackage

// File: rtl/display_scan_ctrl_dwell_timer.sv
// dwell_timer: loadable down-counter with terminal-count flag and synchronous clear
module dwell_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_tc
);
    logic [W-1:0] cnt;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) cnt <= '0;
        else if (i_clr) cnt <= '0;
        else if (i_load) cnt <= i_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    assign o_tc = cnt == '0;
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit seven-segment scan controller with blank gap and double-buffered data
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int SHOW_CYCLES  = 25000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_run,
    input  logic        i_load,
    input  logic [15:0] i_digits,
    input  logic [3:0]  i_dp,
    output logic [1:0]  o_sel,
    output logic        o_ena,
    output logic [3:0]  o_bcd,
    output logic        o_dp,
    output logic        o_frame
);
    localparam int MAXC = SHOW_CYCLES > BLANK_CYCLES ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    state_t state, nstate;
    logic [1:0] idx, nidx;
    logic tload, clr, tc, frame, pend, npend;
    logic [CW-1:0] tval;
    disp_t pending, shadow, nshadow, incoming;
    assign incoming = {i_digits, i_dp};
    dwell_timer #(.W(CW)) u_timer (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(clr), .i_load(tload), .i_val(tval), .o_tc(tc)
    );
    // Timer is loaded with N-1 on state entry so each state lasts exactly N cycles.
    always_comb begin
        nstate = state;
        nidx = idx;
        tload = 1'b0;
        tval = CW'(BLANK_CYCLES - 1);
        clr = 1'b0;
        frame = 1'b0;
        if (!i_run) begin
            nstate = ST_IDLE;
            nidx = '0;
            clr = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    nstate = ST_BLANK;
                    tload = 1'b1;
                end
                ST_BLANK: if (tc) begin
                    nstate = ST_SHOW;
                    tload = 1'b1;
                    tval = CW'(SHOW_CYCLES - 1);
                end
                default: if (tc) begin
                    nstate = ST_BLANK;
                    nidx = idx + 2'd1;
                    tload = 1'b1;
                    frame = idx == 2'd3;
                end
            endcase
        end
    end
    // A load at a frame boundary or while idle bypasses the pending buffer.
    always_comb begin
        nshadow = shadow;
        npend = pend;
        if (i_load && (state == ST_IDLE || frame)) begin
            nshadow = incoming;
            npend = 1'b0;
        end else if (i_load) npend = 1'b1;
        else if (frame && pend) begin
            nshadow = pending;
            npend = 1'b0;
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state <= ST_IDLE;
            idx <= '0;
            pending <= '0;
            shadow <= '0;
            pend <= 1'b0;
            o_sel <= '0;
            o_ena <= 1'b0;
            o_bcd <= '0;
            o_dp <= 1'b0;
            o_frame <= 1'b0;
        end else begin
            state <= nstate;
            idx <= nidx;
            pending <= i_load ? incoming : pending;
            shadow <= nshadow;
            pend <= npend;
            o_sel <= nidx;
            o_ena <= nstate == ST_SHOW;
            o_bcd <= nshadow.digits[nidx*BCD_W +: BCD_W];
            o_dp <= nshadow.dp[nidx];
            o_frame <= frame;
        end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed and random scan checks against a time-position reference model
module tb_display_scan_ctrl;
    localparam int S = 4, B = 2, SLOT = S + B, FR = 4 * SLOT;
    logic i_clk = 0, i_rst_n = 1, i_run = 0, i_load = 0;
    logic [15:0] i_digits = 0;
    logic [3:0] i_dp = 0;
    logic [1:0] o_sel;
    logic o_ena, o_dp, o_frame;
    logic [3:0] o_bcd;
    display_scan_ctrl #(.SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_run(i_run), .i_load(i_load),
        .i_digits(i_digits), .i_dp(i_dp), .o_sel(o_sel), .o_ena(o_ena),
        .o_bcd(o_bcd), .o_dp(o_dp), .o_frame(o_frame)
    );
    always #5 i_clk = ~i_clk;
    int total = 0, passed = 0, fails = 0;
    bit running = 0, pend = 0, exp_frame = 0;
    int t = 0;
    logic [15:0] sh_d = 0, pe_d = 0;
    logic [3:0] sh_p = 0, pe_p = 0;

    task automatic check(string tag, logic [3:0] got, logic [3:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        running = 0; pend = 0; exp_frame = 0; t = 0;
        sh_d = 0; pe_d = 0; sh_p = 0; pe_p = 0;
    endtask

    // Position within the frame is elapsed scan time mod the frame length.
    task automatic step(bit run, bit load, logic [15:0] d, logic [3:0] p);
        int ph, sel;
        i_run = run; i_load = load; i_digits = d; i_dp = p;
        @(posedge i_clk);
        #1;
        i_load = 0;
        exp_frame = 0;
        if (!run) begin
            if (load) begin
                pe_d = d; pe_p = p;
                if (!running) begin sh_d = d; sh_p = p; pend = 0; end
                else pend = 1;
            end
            running = 0; t = 0;
        end else if (!running) begin
            running = 1; t = 0;
            if (load) begin sh_d = d; sh_p = p; pe_d = d; pe_p = p; pend = 0; end
        end else begin
            t++;
            if (t % FR == 0) begin
                exp_frame = 1;
                if (load) begin sh_d = d; sh_p = p; pend = 0; end
                else if (pend) begin sh_d = pe_d; sh_p = pe_p; pend = 0; end
            end else if (load) begin
                pe_d = d; pe_p = p; pend = 1;
            end
        end
        ph = t % FR;
        sel = running ? ph / SLOT : 0;
        check("sel", 4'(o_sel), 4'(sel));
        check("ena", 4'(o_ena), 4'(running && (ph % SLOT) >= B));
        check("frame", 4'(o_frame), 4'(exp_frame));
        check("bcd", o_bcd, 4'(sh_d >> (sel * 4)));
        check("dp", 4'(o_dp), 4'(sh_p[sel]));
    endtask

    task automatic run_to(int ph);
        for (int n = 0; n < 2 * FR && (t % FR) != ph; n++) step(1, 0, 0, 0);
        check("run_to_bound", 4'((t % FR) == ph), 4'd1);
    endtask

    initial begin
        #2 i_rst_n = 0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_sel", 4'(o_sel), 0);
        check("rst_ena", 4'(o_ena), 0);
        check("rst_bcd", o_bcd, 0);
        check("rst_dp", 4'(o_dp), 0);
        check("rst_frame", 4'(o_frame), 0);
        i_rst_n = 1;
        repeat (20) step(0, 0, 0, 0);
        step(0, 1, 16'h4321, 4'b0100);
        repeat (2 * FR) step(1, 0, 0, 0);
        run_to(SLOT + B + 1);
        step(1, 1, 16'h9876, 4'b0011);
        repeat (2 * FR) step(1, 0, 0, 0);
        run_to(10);
        step(1, 1, 16'h1111, 4'b1111);
        run_to(FR - 1);
        step(1, 1, 16'h5555, 4'b1010);
        repeat (FR + 4) step(1, 0, 0, 0);
        run_to(2 * SLOT + B + 1);
        step(0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        repeat (FR + 6) step(1, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 29) != 0, $urandom_range(0, 9) == 0,
                 16'($urandom), 4'($urandom));
        run_to(B + 1);
        #2 i_rst_n = 0;
        #1;
        check("arst_ena", 4'(o_ena), 0);
        check("arst_sel", 4'(o_sel), 0);
        check("arst_bcd", o_bcd, 0);
        model_reset();
        @(posedge i_clk);
        #1 i_rst_n = 1;
        repeat (SLOT + 2) step(1, 0, 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
